servo_pwm: RTL and testbench

- Drives one hobby servo from the 8-bit position produced by the pad-driven up/down position counter.
- Sits directly downstream of that counter and outputs a 50 Hz PWM pulse train.
- Pulse width scales linearly from MIN_PULSE_US to just under MAX_PULSE_US.
- Position and enable are sampled only at period boundaries, so a pulse is never truncated or stretched.

---
 rtl/servo_pkg.sv | 45 ++++
 rtl/us_tick_gen.sv | 30 +++
 rtl/servo_pwm.sv | 116 +++++++++++
 tb/tb_servo_pwm.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared state encoding, derived-constant helpers and parameter sanity checks
// for the hobby-servo PWM generator.
package servo_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // Clock cycles per microsecond.
    function automatic int calc_div(input int clk_freq_hz);
        return clk_freq_hz / 1_000_000;
    endfunction

    function automatic int calc_span(input int min_pulse_us, input int max_pulse_us);
        return max_pulse_us - min_pulse_us;
    endfunction

    // Register width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int width_bits(input int max_pulse_us);
        return $clog2(max_pulse_us + 1);
    endfunction

    // A zero minimum pulse would make the end-of-pulse compare wrap.
    function automatic bit params_ok(
        input int clk_freq_hz,
        input int pos_width,
        input int period_us,
        input int min_pulse_us,
        input int max_pulse_us
    );
        return (clk_freq_hz >= 1_000_000)
            && ((clk_freq_hz % 1_000_000) == 0)
            && (pos_width > 0)
            && (min_pulse_us > 0)
            && (min_pulse_us < max_pulse_us)
            && (max_pulse_us < period_us);
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every DIV clocks. Resets to the last
// count so the very first cycle after reset is already a tick.
module us_tick_gen
    import servo_pkg::*;
#(
    parameter int DIV = 25
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int PW = cnt_width(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc <= PRESC_LAST;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick_o = (presc == PRESC_LAST);

endmodule

// File: rtl/servo_pwm.sv
// 50 Hz servo PWM generator. Position and enable are captured only at period
// boundaries so a pulse is never truncated or stretched mid-flight.
module servo_pwm
    import servo_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 25_000_000,
    parameter int POS_WIDTH    = 8,
    parameter int PERIOD_US    = 20_000,
    parameter int MIN_PULSE_US = 1000,
    parameter int MAX_PULSE_US = 2000
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [POS_WIDTH-1:0]                  pos_i,
    input  logic                                  enable_i,
    output logic                                  pwm_o,
    output logic                                  period_start_o,
    output logic [$clog2(MAX_PULSE_US+1)-1:0]     width_us_o
);

    localparam int DIV      = calc_div(CLK_FREQ_HZ);
    localparam int SPAN     = calc_span(MIN_PULSE_US, MAX_PULSE_US);
    localparam int US_CNT_W = cnt_width(PERIOD_US);
    localparam int WIDTH_W  = width_bits(MAX_PULSE_US);
    localparam int SPAN_W   = $clog2(SPAN + 1);
    localparam int PROD_W   = POS_WIDTH + SPAN_W;

    localparam logic [US_CNT_W-1:0] US_LAST = US_CNT_W'(PERIOD_US - 1);
    localparam logic [WIDTH_W-1:0]  MIN_W   = WIDTH_W'(MIN_PULSE_US);
    localparam logic [PROD_W-1:0]   SPAN_P  = PROD_W'(SPAN);

    generate
        if (!params_ok(CLK_FREQ_HZ, POS_WIDTH, PERIOD_US, MIN_PULSE_US, MAX_PULSE_US)) begin : g_bad_params
            $error("servo_pwm: inconsistent parameter set");
        end
    endgenerate

    logic                tick;
    logic                pb;
    logic [US_CNT_W-1:0] us_cnt;
    logic [US_CNT_W-1:0] pulse_last;
    logic [PROD_W-1:0]   prod;
    logic [WIDTH_W-1:0]  width_d;
    logic [WIDTH_W-1:0]  width_q;
    logic                pwm_q;
    state_t              state_q;
    state_t              state_d;

    us_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tick_o(tick)
    );

    // The prescaler wraps on the same tick, so presc and us_cnt restart together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            us_cnt <= US_LAST;
        end else if (tick) begin
            us_cnt <= (us_cnt == US_LAST) ? '0 : us_cnt + 1'b1;
        end
    end

    assign pb = tick && (us_cnt == US_LAST);

    // Full-width product; the shifted result is at most SPAN-1, so it fits WIDTH_W.
    always_comb begin
        prod    = PROD_W'(pos_i) * SPAN_P;
        width_d = MIN_W + WIDTH_W'(prod >> POS_WIDTH);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            width_q <= MIN_W;
        end else if (pb) begin
            width_q <= width_d;
        end
    end

    assign pulse_last = US_CNT_W'(width_q - 1'b1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_OFF;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pwm_q   <= (state_d == ST_HIGH);
        end
    end

    always_comb begin
        state_d = state_q;
        if (pb) begin
            state_d = enable_i ? ST_HIGH : ST_OFF;
        end else begin
            case (state_q)
                ST_HIGH: begin
                    if (tick && (us_cnt == pulse_last)) begin
                        state_d = ST_LOW;
                    end
                end
                ST_LOW:  state_d = ST_LOW;
                ST_OFF:  state_d = ST_OFF;
                default: state_d = ST_OFF;
            endcase
        end
    end

    assign pwm_o          = pwm_q;
    assign period_start_o = pb && !rst_i;
    assign width_us_o     = width_q;

endmodule

// File: tb/tb_servo_pwm.sv
// Randomized self-checking bench for servo_pwm, scaled down (DIV=2, 1100 us
// period, 10-bit position, 1000 us span) to keep periods short.
module tb_servo_pwm;

    localparam int CLK_FREQ_HZ  = 2_000_000;
    localparam int DIV          = CLK_FREQ_HZ / 1_000_000;
    localparam int POS_WIDTH    = 10;
    localparam int PERIOD_US    = 1100;
    localparam int MIN_PULSE_US = 10;
    localparam int MAX_PULSE_US = 1010;
    localparam int SPAN         = MAX_PULSE_US - MIN_PULSE_US;
    localparam int PERIOD_CYC   = PERIOD_US * DIV;
    localparam int WIDTH_W      = $clog2(MAX_PULSE_US + 1);

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [POS_WIDTH-1:0] pos_i;
    logic                 enable_i;
    logic                 pwm_o;
    logic                 period_start_o;
    logic [WIDTH_W-1:0]   width_us_o;

    int nChecks = 0;
    int nFails  = 0;

    servo_pwm #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .POS_WIDTH   (POS_WIDTH),
        .PERIOD_US   (PERIOD_US),
        .MIN_PULSE_US(MIN_PULSE_US),
        .MAX_PULSE_US(MAX_PULSE_US)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .pos_i         (pos_i),
        .enable_i      (enable_i),
        .pwm_o         (pwm_o),
        .period_start_o(period_start_o),
        .width_us_o    (width_us_o)
    );

    always #5 clk = ~clk;

    // Reference: linear position-to-microseconds map with floor division.
    function automatic int expWidth(input int pos);
        return MIN_PULSE_US + (pos * SPAN) / (2 ** POS_WIDTH);
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_pwm", int'(pwm_o), 0);
        checkOutput("rst_strobe", int'(period_start_o), 0);
        checkOutput("rst_width", int'(width_us_o), MIN_PULSE_US);
        rst_i = 1'b0;
        #1;
        checkOutput("first_pb_strobe", int'(period_start_o), 1);
    endtask

    // Entered inside a boundary cycle; runs one full period and returns in the next one.
    task automatic applyStimulus(input int pos, input bit en, input int chgCycle,
                                 input int pos2, input bit en2);
        int w;
        int hiCnt;
        int shapeErr;
        int strobeErr;
        bit expPwm;
        pos_i     = POS_WIDTH'(pos);
        enable_i  = en;
        w         = expWidth(pos);
        hiCnt     = 0;
        shapeErr  = 0;
        strobeErr = 0;
        for (int c = 1; c <= PERIOD_CYC; c++) begin
            @(negedge clk);
            if (c == 1) checkOutput("width_us", int'(width_us_o), w);
            expPwm = en && (c <= w * DIV);
            if (pwm_o === 1'b1) hiCnt++;
            if (pwm_o !== expPwm) shapeErr++;
            if (period_start_o !== (c == PERIOD_CYC)) strobeErr++;
            if (c == chgCycle) begin
                pos_i    = POS_WIDTH'(pos2);
                enable_i = en2;
            end
        end
        checkOutput("high_cycles", hiCnt, en ? w * DIV : 0);
        checkOutput("pwm_shape_errs", shapeErr, 0);
        checkOutput("strobe_errs", strobeErr, 0);
    endtask

    initial begin
        int rp;
        int rp2;
        bit ren;
        bit ren2;
        int rc;
        rst_i    = 1'b1;
        pos_i    = '0;
        enable_i = 1'b1;

        doReset();
        applyStimulus(0, 1'b1, 0, 0, 1'b1);
        applyStimulus(512, 1'b1, 0, 0, 1'b1);
        applyStimulus(1023, 1'b1, 0, 0, 1'b1);
        applyStimulus(0, 1'b1, 5, 1023, 1'b1);
        applyStimulus(1023, 1'b1, 0, 0, 1'b1);
        applyStimulus(300, 1'b0, 0, 0, 1'b1);
        applyStimulus(700, 1'b1, 100, 700, 1'b0);
        applyStimulus(700, 1'b0, 0, 0, 1'b1);

        // Reset landing in the middle of a pulse.
        pos_i    = POS_WIDTH'(512);
        enable_i = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("pulse_before_rst", int'(pwm_o), 1);
        rst_i = 1'b1;
        @(negedge clk);
        checkOutput("pwm_after_rst", int'(pwm_o), 0);
        @(negedge clk);
        checkOutput("width_after_rst", int'(width_us_o), MIN_PULSE_US);
        rst_i = 1'b0;
        #1;
        checkOutput("pb_after_rst", int'(period_start_o), 1);

        for (int i = 0; i < 8; i++) begin
            rp   = int'($urandom_range(0, 1023));
            rp2  = int'($urandom_range(0, 1023));
            ren  = ($urandom_range(0, 3) != 0);
            ren2 = $urandom_range(0, 1) != 0;
            rc   = int'($urandom_range(1, PERIOD_CYC - 1));
            applyStimulus(rp, ren, rc, rp2, ren2);
        end

        $display("test done: total=%0d bad=%0d", nChecks, nFails);
        $finish;
    end

endmodule
